// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle RV32I control path.
// Holds the controller state enum, the supported opcodes and the encodings
// of the datapath mux selects. Imported by the controller, the immediate
// source decoder and the testbench.
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECR,
    EXECI,
    ALUWB,
    BEQ,
    JAL,
    TRAP
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_if.sv
// Memory handshake between the multicycle controller and the unified
// instruction/data memory.
//   mem_req   : controller requests an access this cycle
//   mem_ready : memory completes the current access this cycle
//   AdrSrc    : address select, 0 = PC, 1 = ALUOut
//   MemWrite  : the requested access is a write
interface multicycle_controller_if;
  logic mem_req;
  logic mem_ready;
  logic AdrSrc;
  logic MemWrite;

  modport master (output mem_req, output AdrSrc, output MemWrite, input mem_ready);
  modport slave  (input mem_req, input AdrSrc, input MemWrite, output mem_ready);
endinterface

// File: rtl/imm_src_dec.sv
// Immediate format select decoded purely from the opcode.
// Shared between the single-cycle and multicycle control paths.
//   op     : instruction opcode
//   ImmSrc : 00 I-type, 01 S-type, 10 B-type, 11 J-type
module imm_src_dec
  import multicycle_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] ImmSrc
);

  // Unsupported opcodes fall back to the I-type format; the controller traps
  // on them anyway, so the value only has to be defined.
  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I datapath (lw, sw, R-type, I-type ALU,
// beq, jal). One shared ALU and one unified memory are sequenced over several
// cycles per instruction.
//   clk, reset      : rising-edge clock, asynchronous active-low reset
//   op, Zero        : opcode from the instruction register, ALU zero flag
//   mem             : memory handshake (mem_req/mem_ready/AdrSrc/MemWrite)
//   IRWrite..ImmSrc : datapath strobes and mux selects
//   illegal_instr   : set once an unsupported opcode has been decoded
//   instr_retired   : one-cycle pulse when an instruction completes
//   retired_count   : wrapping count of completed instructions
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            op,
  input  logic                  Zero,
  multicycle_controller_if.master mem,
  output logic                  IRWrite,
  output logic                  PCWrite,
  output logic                  RegWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ALUOp,
  output logic [1:0]            ImmSrc,
  output logic                  illegal_instr,
  output logic                  instr_retired,
  output logic [RETIRE_W-1:0]   retired_count
);

  state_t state;
  state_t next_state;
  logic   mem_req_raw;
  logic   mem_write_raw;
  logic   ir_write_raw;
  logic   reg_write_raw;
  logic   pc_update;
  logic   branch;
  logic   retire_raw;

  imm_src_dec u_imm_src_dec (
    .op     (op),
    .ImmSrc (ImmSrc)
  );

  // Per-state decode. Everything defaults to 0; each state only lists what it
  // drives. The memory-waiting states hold themselves until mem_ready.
  always_comb begin
    next_state    = state;
    mem_req_raw   = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;
    retire_raw    = 1'b0;
    mem.AdrSrc    = 1'b0;
    ResultSrc     = RES_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RS2;
    ALUOp         = ALUOP_ADD;
    case (state)
      FETCH: begin
        mem_req_raw  = 1'b1;
        ALUSrcB      = SRCB_FOUR;
        ResultSrc    = RES_ALURESULT;
        // IR load and PC+4 only on the cycle the fetch completes, so the PC
        // advances exactly once however long the memory stalls.
        ir_write_raw = mem.mem_ready;
        pc_update    = mem.mem_ready;
        if (mem.mem_ready) next_state = DECODE;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECR;
          OP_I:         next_state = EXECI;
          OP_BEQ:       next_state = BEQ;
          OP_JAL:       next_state = JAL;
          default:      next_state = TRAP;
        endcase
      end
      MEMADR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        next_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        mem_req_raw = 1'b1;
        mem.AdrSrc  = 1'b1;
        if (mem.mem_ready) next_state = MEMWB;
      end
      MEMWB: begin
        ResultSrc     = RES_DATA;
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
        next_state    = FETCH;
      end
      MEMWRITE: begin
        mem_req_raw   = 1'b1;
        mem.AdrSrc    = 1'b1;
        mem_write_raw = 1'b1;
        if (mem.mem_ready) begin
          retire_raw = 1'b1;
          next_state = FETCH;
        end
      end
      EXECR: begin
        ALUSrcA    = SRCA_RS1;
        ALUOp      = ALUOP_FUNCT;
        next_state = ALUWB;
      end
      EXECI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ALUOp      = ALUOP_FUNCT;
        next_state = ALUWB;
      end
      ALUWB: begin
        ResultSrc     = RES_ALUOUT;
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
        next_state    = FETCH;
      end
      BEQ: begin
        ALUSrcA    = SRCA_RS1;
        ALUOp      = ALUOP_SUB;
        branch     = 1'b1;
        retire_raw = 1'b1;
        next_state = FETCH;
      end
      JAL: begin
        // ALUOut still holds the jump target from DECODE; this cycle computes
        // OldPC+4 for the link register written in ALUWB.
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        pc_update  = 1'b1;
        next_state = ALUWB;
      end
      TRAP: begin
        next_state = TRAP;
      end
      default: begin
        next_state = FETCH;
      end
    endcase
  end

  // Strobes are masked while reset is held so nothing in the datapath moves
  // even though the state register already reads FETCH.
  always_comb begin
    mem.mem_req   = mem_req_raw & reset;
    mem.MemWrite  = mem_write_raw & reset;
    IRWrite       = ir_write_raw & reset;
    RegWrite      = reg_write_raw & reset;
    PCWrite       = (pc_update | (branch & Zero)) & reset;
    instr_retired = retire_raw & reset;
    illegal_instr = (state == TRAP);
  end

  // State register and retirement counter. TRAP is absorbing, so the illegal
  // flag derived from it stays set until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= FETCH;
      retired_count <= '0;
    end else begin
      state <= next_state;
      if (retire_raw) retired_count <= retired_count + RETIRE_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller. A stimulus process
// issues instructions and pushes the expected per-instruction profile (cycle
// count, strobe counts, result select on writeback, retire count); a monitor
// accumulates observed strobes every cycle and compares on each retire pulse.
// A memory responder inserts a chosen number of stall cycles per access.
module tb_multicycle_controller;
  import multicycle_pkg::*;

  localparam int RETIRE_W = 32;

  typedef struct {
    int          cycles;
    int          pcw;
    int          irw;
    int          mw;
    int          rw;
    logic [1:0]  rsrc;
    int          count;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [6:0]          op = OP_R;
  logic                Zero = 1'b0;
  logic                IRWrite, PCWrite, RegWrite;
  logic [1:0]          ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic                illegal_instr, instr_retired;
  logic [RETIRE_W-1:0] retired_count;

  multicycle_controller_if mif ();

  multicycle_controller #(.RETIRE_W(RETIRE_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .op            (op),
    .Zero          (Zero),
    .mem           (mif),
    .IRWrite       (IRWrite),
    .PCWrite       (PCWrite),
    .RegWrite      (RegWrite),
    .ResultSrc     (ResultSrc),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .ALUOp         (ALUOp),
    .ImmSrc        (ImmSrc),
    .illegal_instr (illegal_instr),
    .instr_retired (instr_retired),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sbq[$];
  int   stallq[$];
  bit   monOn = 1'b0;

  task automatic checkOutput(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic logic [1:0] immFor(input logic [6:0] o);
    if (o == OP_SW) return 2'b01;
    if (o == OP_BEQ) return 2'b10;
    if (o == OP_JAL) return 2'b11;
    return 2'b00;
  endfunction

  // Memory responder: each access takes the next stall count from stallq and
  // holds mem_ready low that many cycles. Outside accesses mem_ready is noise.
  int respCnt = 0;
  bit respLoaded = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      respLoaded = 1'b0;
      respCnt = 0;
      mif.mem_ready = 1'b0;
    end else if (mif.mem_req) begin
      if (!respLoaded) begin
        respCnt = (stallq.size() > 0) ? stallq.pop_front() : 0;
        respLoaded = 1'b1;
      end
      if (respCnt > 0) begin
        mif.mem_ready = 1'b0;
        respCnt--;
      end else begin
        mif.mem_ready = 1'b1;
        respLoaded = 1'b0;
      end
    end else begin
      mif.mem_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: accumulate strobes per instruction, compare on retire.
  int         cyc = 0, pcw = 0, irw = 0, mw = 0, rw = 0, immBad = 0;
  logic [1:0] rsrc = 2'b11;
  always @(negedge clk) begin
    #2;
    if (monOn) begin
      cyc++;
      pcw += int'(PCWrite);
      irw += int'(IRWrite);
      mw  += int'(mif.MemWrite);
      rw  += int'(RegWrite);
      if (RegWrite) rsrc = ResultSrc;
      if (ImmSrc !== immFor(op)) immBad++;
      if (instr_retired) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_retire", sbq.size(), 1);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          checkOutput("cycles", cyc, e.cycles);
          checkOutput("pcwrite_count", pcw, e.pcw);
          checkOutput("irwrite_count", irw, e.irw);
          checkOutput("memwrite_count", mw, e.mw);
          checkOutput("regwrite_count", rw, e.rw);
          if (e.rw > 0) checkOutput("resultsrc_wb", rsrc, e.rsrc);
          checkOutput("retired_count", retired_count, e.count);
          checkOutput("immsrc_bad_cycles", immBad, 0);
        end
        cyc = 0; pcw = 0; irw = 0; mw = 0; rw = 0; immBad = 0; rsrc = 2'b11;
      end
    end
  end

  // Issue one instruction with given fetch/data stalls and wait for retire.
  int modelCount = 0;
  bit alive = 1'b1;
  task automatic applyStimulus(input int kind, input int fs, input int ds, input bit z);
    exp_t e;
    logic [6:0] ops [6];
    bit got;
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};
    stallq.push_back(fs);
    if (kind <= 1) stallq.push_back(ds);
    case (kind)
      0:       e.cycles = 5 + fs + ds;
      1:       e.cycles = 4 + fs + ds;
      4:       e.cycles = 3 + fs;
      default: e.cycles = 4 + fs;
    endcase
    e.pcw   = 1 + ((kind == 4 && z) ? 1 : 0) + ((kind == 5) ? 1 : 0);
    e.irw   = 1;
    e.mw    = (kind == 1) ? ds + 1 : 0;
    e.rw    = (kind == 1 || kind == 4) ? 0 : 1;
    e.rsrc  = (kind == 0) ? 2'b01 : 2'b00;
    e.count = modelCount;
    sbq.push_back(e);
    op = ops[kind];
    Zero = z;
    if (!reset) begin
      reset = 1'b1;
      monOn = 1'b1;
    end
    got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      #3;
      got = instr_retired;
    end
    if (!got) begin
      checkOutput("retire_timeout", 0, 1);
      alive = 1'b0;
      stallq.delete();
      sbq.delete();
    end
    modelCount++;
    @(posedge clk);
    #1;
  endtask

  int strobeCyc, illCyc, fetchStrobes;
  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_mem_req", mif.mem_req, 0);
    checkOutput("rst_irwrite", IRWrite, 0);
    checkOutput("rst_pcwrite", PCWrite, 0);
    checkOutput("rst_retired_count", retired_count, 0);
    checkOutput("rst_illegal", illegal_instr, 0);
    @(posedge clk);
    #1;

    // Directed openers: lw no stall, sw 3-cycle stall, beq taken/not, jal.
    applyStimulus(0, 0, 0, 1'b0);
    if (alive) applyStimulus(1, 0, 3, 1'b0);
    if (alive) applyStimulus(4, 0, 0, 1'b1);
    if (alive) applyStimulus(4, 0, 0, 1'b0);
    if (alive) applyStimulus(5, 0, 0, 1'b0);
    for (int i = 0; i < 60 && alive; i++)
      applyStimulus($urandom_range(0, 5), $urandom_range(0, 3),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    monOn = 1'b0;

    // Recover to a known point, then illegal opcode into TRAP.
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    stallq.delete();
    stallq.push_back(0);
    op = 7'b1111111;
    @(posedge clk);
    @(posedge clk);
    #1;
    strobeCyc = 0;
    illCyc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #3;
      if (mif.mem_req | IRWrite | PCWrite | mif.MemWrite | RegWrite | instr_retired) strobeCyc++;
      if (illegal_instr) illCyc++;
    end
    checkOutput("trap_strobe_cycles", strobeCyc, 0);
    checkOutput("trap_illegal_cycles", illCyc, 20);
    checkOutput("trap_retired_count", retired_count, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    checkOutput("trap_rst_illegal", illegal_instr, 0);
    checkOutput("trap_rst_mem_req", mif.mem_req, 0);

    // Fetch stall of 5 with reset asserted part-way through.
    @(posedge clk);
    #1;
    op = OP_LW;
    stallq.delete();
    stallq.push_back(5);
    reset = 1'b1;
    fetchStrobes = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #3;
      fetchStrobes += int'(IRWrite | PCWrite);
    end
    checkOutput("stall_mem_req", mif.mem_req, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    #3;
    fetchStrobes += int'(IRWrite | PCWrite | mif.mem_req);
    checkOutput("stall_strobes", fetchStrobes, 0);
    checkOutput("stall_retired_count", retired_count, 0);
    @(posedge clk);
    #1;
    stallq.delete();
    stallq.push_back(0);
    reset = 1'b1;
    @(negedge clk);
    #3;
    checkOutput("resume_irwrite", IRWrite, 1);
    checkOutput("resume_pcwrite", PCWrite, 1);
    @(negedge clk);
    #3;
    checkOutput("resume_decode_irwrite", IRWrite, 0);
    checkOutput("resume_retired_count", retired_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM for the multicycle RV32I datapath variant (lw, sw, R-type, I-type ALU, beq, jal).
- Sequences one shared ALU/adder and one unified instruction/data memory across several cycles per instruction.
- Emits per-state mux selects and write strobes, and handles a memory ready handshake.
- Sits beside the existing ALU decoder: ALUOp goes to aludec, which is unchanged.

Parameters:
- RETIRE_W, 32, width of the retired-instruction counter (wraps modulo 2^RETIRE_W).

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- op  in  7  instruction opcode, taken from the instruction register.
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current access this cycle.
- mem_req  out  1  memory access requested this cycle.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  load the instruction register.
- PCWrite  out  1  load the PC.
- MemWrite  out  1  memory write enable.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4.
- ALUOp  out  2  to aludec.
- ImmSrc  out  2  immediate format select.
- illegal_instr  out  1  sticky flag: unsupported opcode decoded.
- instr_retired  out  1  one-cycle pulse when an instruction completes.
- retired_count  out  RETIRE_W  number of completed instructions.

Behaviour:
- Registered state; all outputs combinational from state, op, Zero and mem_ready. Moore-style except the strobes gated by mem_ready and Zero.
- PCWrite = PCUpdate | (Branch & Zero). PCUpdate and Branch are internal.
- Default for every output in every state is 0 unless listed below.
- FETCH:
  - mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=PCUpdate=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when it is 1. PC therefore advances exactly once per fetch.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut).
  - Next state by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL; any other -> TRAP.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD if op=lw, else MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00. Holds until mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Retires, then FETCH.
- MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1, held high through the wait. On mem_ready it retires, then FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Retires, then FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Retires, then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Goes to ALUWB, where rd is written with PC+4.
- TRAP: absorbing state with all strobes 0; illegal_instr=1. Only reset leaves it.
- ImmSrc is decoded from op in every state: lw 00, I-type 00, sw 01, beq 10, jal 11, others 00.
- Retirement:
  - instr_retired=1 in the retiring cycle.
  - retired_count increments on that same clock edge and wraps from all-ones to 0.
- Reset:
  - When reset is low: state=FETCH, illegal_instr=0, retired_count=0.
  - mem_req, IRWrite, PCWrite, MemWrite, RegWrite and instr_retired are forced to 0 while reset is low.
  - Reset mid-instruction (including during a memory wait) abandons the instruction without counting it.
- mem_ready is ignored in states that do not request memory.

Decomposition:
- Package multicycle_pkg holds:
  - the state enum (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP);
  - opcode localparams (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL);
  - encodings for ResultSrc, ALUSrcA and ALUSrcB.
- One sub-module: imm_src_dec (op -> ImmSrc, combinational), shared with the single-cycle path.

Test Plan:
- lw with mem_ready tied 1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB over 5 cycles; RegWrite=1 and ResultSrc=01 in cycle 5; retired_count 0 -> 1.
- sw with mem_ready low for 3 cycles in MEMWRITE -> MemWrite high for 4 consecutive cycles; instr_retired pulses once, on the ready cycle; 4 + 3 = 7 cycles total.
- beq with Zero=1, then beq with Zero=0 -> PCWrite=1 in the BEQ cycle only for the first; each takes 3 cycles; count +2.
- jal -> FETCH, DECODE, JAL, ALUWB; PCWrite in JAL; RegWrite with ResultSrc=00 in ALUWB; ImmSrc=11 throughout.
- op=7'b1111111 -> TRAP after DECODE; illegal_instr=1 and all strobes 0 for 20 cycles; reset pulse -> FETCH with illegal_instr=0.
- Fetch stall of 5 cycles, reset asserted mid-stall -> IRWrite and PCWrite never asserted; retired_count=0; after reset release, FETCH resumes.
